// File: rtl/time_set_ctrl.sv
// Keypad time-setting sequencer: collects six range-checked BCD digits (HHMMSS)
// and issues a one-cycle load strobe to the watch counters on Enter.
module time_set_ctrl #(
   parameter int ERR_HOLD_CYC = 1000,
   parameter int TIMEOUT_CYC  = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        busy,
   output logic [23:0] entry_bcd,
   output logic [2:0]  digit_cnt,
   output logic        load_en,
   output logic [23:0] load_bcd,
   output logic        err
);

   localparam int ERR_W = $clog2(ERR_HOLD_CYC + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, ENTRY, ERROR} state_t;

   state_t            r_state, w_state_nxt;
   logic [23:0]       r_bcd, w_bcd_nxt;
   logic [2:0]        r_cnt, w_cnt_nxt;
   logic              r_busy;
   logic              r_load_en, w_load_en_nxt;
   logic [23:0]       r_load_bcd, w_load_bcd_nxt;
   logic              r_err, w_err_nxt;
   logic [ERR_W-1:0]  r_err_cnt, w_err_cnt_nxt;
   logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;

   // Upper digit limit depends on position; h_one is capped at 3 only for hours 20-23.
   function automatic logic digit_ok(input logic [2:0] pos, input logic [3:0] d,
                                     input logic [3:0] h_ten);
      logic ok;
      case (pos)
         3'd0:       ok = (d <= 4'd2);
         3'd1:       ok = (h_ten == 4'd2) ? (d <= 4'd3) : (d <= 4'd9);
         3'd2, 3'd4: ok = (d <= 4'd5);
         default:    ok = (d <= 4'd9);
      endcase
      return ok;
   endfunction

   always_comb begin
      w_state_nxt    = r_state;
      w_bcd_nxt      = r_bcd;
      w_cnt_nxt      = r_cnt;
      w_load_en_nxt  = 1'b0;
      w_load_bcd_nxt = r_load_bcd;
      w_err_nxt      = r_err;
      w_err_cnt_nxt  = r_err_cnt;
      w_to_cnt_nxt   = r_to_cnt;
      case (r_state)
         IDLE: begin
            if (key_valid && key_code == 4'hA) begin
               w_state_nxt  = ENTRY;
               w_bcd_nxt    = '0;
               w_cnt_nxt    = '0;
               w_to_cnt_nxt = '0;
            end
         end
         ENTRY: begin
            if (key_valid) begin
               w_to_cnt_nxt = '0;
               if (key_code <= 4'd9) begin
                  if (r_cnt < 3'd6) begin
                     if (digit_ok(r_cnt, key_code, r_bcd[23:20])) begin
                        for (int i = 0; i < 6; i++)
                           if (r_cnt == 3'(i)) w_bcd_nxt[23-4*i -: 4] = key_code;
                        w_cnt_nxt = r_cnt + 3'd1;
                     end else begin
                        w_state_nxt   = ERROR;
                        w_err_nxt     = 1'b1;
                        w_err_cnt_nxt = '0;
                     end
                  end
               end else begin
                  case (key_code)
                     4'hB: begin
                        if (r_cnt != 3'd0) begin
                           for (int i = 0; i < 6; i++)
                              if (r_cnt == 3'(i + 1)) w_bcd_nxt[23-4*i -: 4] = 4'd0;
                           w_cnt_nxt = r_cnt - 3'd1;
                        end
                     end
                     4'hC: begin
                        w_state_nxt = IDLE;
                        w_bcd_nxt   = '0;
                        w_cnt_nxt   = '0;
                     end
                     4'hA: begin
                        w_bcd_nxt = '0;
                        w_cnt_nxt = '0;
                     end
                     4'hF: begin
                        if (r_cnt == 3'd6) begin
                           w_load_en_nxt  = 1'b1;
                           w_load_bcd_nxt = r_bcd;
                           w_state_nxt    = IDLE;
                           w_bcd_nxt      = '0;
                           w_cnt_nxt      = '0;
                        end else begin
                           w_state_nxt   = ERROR;
                           w_err_nxt     = 1'b1;
                           w_err_cnt_nxt = '0;
                        end
                     end
                     default: ;
                  endcase
               end
            end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
               w_state_nxt  = IDLE;
               w_bcd_nxt    = '0;
               w_cnt_nxt    = '0;
               w_to_cnt_nxt = '0;
            end else begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
         end
         ERROR: begin
            w_to_cnt_nxt = '0;
            // Counter started at 0 on the rejecting edge, so err spans exactly ERR_HOLD_CYC cycles.
            if (r_err_cnt == ERR_W'(ERR_HOLD_CYC - 1)) begin
               w_state_nxt   = ENTRY;
               w_err_nxt     = 1'b0;
               w_err_cnt_nxt = '0;
            end else begin
               w_err_cnt_nxt = r_err_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_load_en  <= 1'b0;
         r_load_bcd <= '0;
         r_err      <= 1'b0;
         r_err_cnt  <= '0;
         r_to_cnt   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_bcd      <= w_bcd_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_load_en  <= w_load_en_nxt;
         r_load_bcd <= w_load_bcd_nxt;
         r_err      <= w_err_nxt;
         r_err_cnt  <= w_err_cnt_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
      end
   end

   assign busy      = r_busy;
   assign entry_bcd = r_bcd;
   assign digit_cnt = r_cnt;
   assign load_en   = r_load_en;
   assign load_bcd  = r_load_bcd;
   assign err       = r_err;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random key traffic checked
// cycle by cycle against a queue-based model of the digit-entry rules.
module tb_time_set_ctrl;

   localparam int ERR_HOLD = 1000;
   localparam int TIMEOUT  = 10000;
   localparam int M_IDLE = 0, M_ENTRY = 1, M_ERROR = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        busy, load_en, err;
   logic [23:0] entry_bcd, load_bcd;
   logic [2:0]  digit_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int n_loads  = 0;

   int          m_mode = M_IDLE;
   int          m_dig[$];
   int          m_err_left = 0;
   int          m_idle = 0;
   logic        m_load = 1'b0;
   logic [23:0] m_load_bcd = '0;

   time_set_ctrl #(.ERR_HOLD_CYC(ERR_HOLD), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .busy(busy), .entry_bcd(entry_bcd), .digit_cnt(digit_cnt),
      .load_en(load_en), .load_bcd(load_bcd), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] m_pack();
      logic [23:0] v = '0;
      for (int i = 0; i < m_dig.size(); i++) v = v | (24'(m_dig[i]) << (20 - 4 * i));
      return v;
   endfunction

   function automatic bit m_digit_ok(int pos, int d);
      if (pos == 0) return d <= 2;
      if (pos == 1) return (m_dig[0] == 2) ? (d <= 3) : 1'b1;
      if (pos == 2 || pos == 4) return d <= 5;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_dig.delete(); m_err_left = 0; m_idle = 0;
      m_load = 1'b0; m_load_bcd = '0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] c);
      m_load = 1'b0;
      if (m_mode == M_IDLE) begin
         if (v && c == 4'hA) begin m_mode = M_ENTRY; m_dig.delete(); m_idle = 0; end
      end else if (m_mode == M_ENTRY) begin
         if (v) begin
            m_idle = 0;
            if (c <= 4'd9) begin
               if (m_dig.size() < 6) begin
                  if (m_digit_ok(m_dig.size(), int'(c))) m_dig.push_back(int'(c));
                  else begin m_mode = M_ERROR; m_err_left = ERR_HOLD; end
               end
            end else if (c == 4'hB) begin
               if (m_dig.size() > 0) void'(m_dig.pop_back());
            end else if (c == 4'hC) begin
               m_mode = M_IDLE; m_dig.delete();
            end else if (c == 4'hA) begin
               m_dig.delete();
            end else if (c == 4'hF) begin
               if (m_dig.size() == 6) begin
                  m_load = 1'b1; m_load_bcd = m_pack(); m_dig.delete(); m_mode = M_IDLE;
               end else begin
                  m_mode = M_ERROR; m_err_left = ERR_HOLD;
               end
            end
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_mode = M_IDLE; m_dig.delete(); end
         end
      end else begin
         m_err_left--;
         if (m_err_left == 0) begin m_mode = M_ENTRY; m_idle = 0; end
      end
   endtask

   task automatic tick(input logic v, input logic [3:0] c);
      key_valid = v; key_code = c;
      @(posedge clk);
      model_step(v, c);
      #1;
      key_valid = 1'b0;
      if (load_en === 1'b1) n_loads++;
   endtask

   task automatic press(input logic [3:0] c);
      tick(1'b1, c);
   endtask

   task automatic test_reset();
      model_reset();
      #3;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", busy); end
      n_checks++; if (entry_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_entry got %h exp 0", entry_bcd); end
      n_checks++; if (digit_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", digit_cnt); end
      n_checks++; if (load_en !== 1'b0 || load_bcd !== 24'h0) begin n_fail++; $display("FAIL reset_load got %0b/%h exp 0/0", load_en, load_bcd); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err); end
      @(negedge clk); rst = 1'b1;
      press(4'hA); press(4'd1); press(4'd2); press(4'd3);
      n_checks++; if (digit_cnt !== 3'd3 || entry_bcd !== 24'h123000) begin n_fail++; $display("FAIL pre_reset_entry got %0d/%h exp 3/123000", digit_cnt, entry_bcd); end
      #2 rst = 1'b0;
      model_reset();
      #1;
      n_checks++; if ({busy, load_en, err} !== 3'b000 || entry_bcd !== 24'h0 || digit_cnt !== 3'd0 || load_bcd !== 24'h0) begin
         n_fail++; $display("FAIL midreset_outputs got busy=%0b ld=%0b err=%0b ent=%h cnt=%0d lbcd=%h exp all 0", busy, load_en, err, entry_bcd, digit_cnt, load_bcd); end
      #2 rst = 1'b1;
      tick(1'b0, 4'h0);
      n_checks++; if (busy !== 1'b0 || n_loads != 0) begin n_fail++; $display("FAIL midreset_idle got busy=%0b loads=%0d exp 0/0", busy, n_loads); end
      press(4'hA);
      n_checks++; if (busy !== 1'b1 || digit_cnt !== 3'd0) begin n_fail++; $display("FAIL post_reset_start got busy=%0b cnt=%0d exp 1/0", busy, digit_cnt); end
      press(4'hC);
   endtask

   task automatic test_full_load();
      int l0 = n_loads;
      press(4'hA); press(4'd2); press(4'd3); press(4'd5); press(4'd9); press(4'd5); press(4'd9);
      n_checks++; if (digit_cnt !== 3'd6 || entry_bcd !== 24'h235959) begin n_fail++; $display("FAIL full_entry got %0d/%h exp 6/235959", digit_cnt, entry_bcd); end
      press(4'hF);
      n_checks++; if (load_en !== 1'b1 || load_bcd !== 24'h235959) begin n_fail++; $display("FAIL full_load got %0b/%h exp 1/235959", load_en, load_bcd); end
      n_checks++; if (busy !== 1'b0 || entry_bcd !== 24'h0 || digit_cnt !== 3'd0) begin n_fail++; $display("FAIL full_after got busy=%0b ent=%h cnt=%0d exp 0/0/0", busy, entry_bcd, digit_cnt); end
      tick(1'b0, 4'h0);
      n_checks++; if (load_en !== 1'b0 || load_bcd !== 24'h235959) begin n_fail++; $display("FAIL full_pulse_end got %0b/%h exp 0/235959", load_en, load_bcd); end
      n_checks++; if (n_loads - l0 != 1) begin n_fail++; $display("FAIL full_pulse_count got %0d exp 1", n_loads - l0); end
   endtask

   task automatic test_error_hold();
      int l0 = n_loads;
      int bad = 0;
      press(4'hA); press(4'd2); press(4'd4);
      n_checks++; if (err !== 1'b1 || busy !== 1'b1 || entry_bcd !== 24'h200000 || digit_cnt !== 3'd1) begin
         n_fail++; $display("FAIL err_enter got err=%0b busy=%0b ent=%h cnt=%0d exp 1/1/200000/1", err, busy, entry_bcd, digit_cnt); end
      for (int k = 1; k < ERR_HOLD; k++) begin
         press(4'($urandom_range(0, 15)));
         if (err !== 1'b1 || entry_bcd !== 24'h200000 || digit_cnt !== 3'd1 || busy !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL err_hold got %0d bad cycles exp 0", bad); end
      press(4'd0);
      n_checks++; if (err !== 1'b0 || busy !== 1'b1 || entry_bcd !== 24'h200000 || digit_cnt !== 3'd1) begin
         n_fail++; $display("FAIL err_release got err=%0b busy=%0b ent=%h cnt=%0d exp 0/1/200000/1", err, busy, entry_bcd, digit_cnt); end
      press(4'd1); press(4'd0); press(4'd0); press(4'd0); press(4'd0); press(4'hF);
      n_checks++; if (load_en !== 1'b1 || load_bcd !== 24'h210000 || n_loads - l0 != 1) begin
         n_fail++; $display("FAIL err_then_load got %0b/%h loads=%0d exp 1/210000/1", load_en, load_bcd, n_loads - l0); end
   endtask

   task automatic test_backspace();
      int l0 = n_loads;
      logic [2:0] steps [5] = '{3'd1, 3'd2, 3'd1, 3'd0, 3'd0};
      logic [3:0] keys  [5] = '{4'd1, 4'd7, 4'hB, 4'hB, 4'hB};
      press(4'hA);
      for (int i = 0; i < 5; i++) begin
         press(keys[i]);
         n_checks++; if (digit_cnt !== steps[i]) begin n_fail++; $display("FAIL bksp_step%0d got %0d exp %0d", i, digit_cnt, steps[i]); end
      end
      n_checks++; if (entry_bcd !== 24'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL bksp_clear got %h/%0b exp 0/1", entry_bcd, busy); end
      press(4'd1); press(4'd9); press(4'd6);
      n_checks++; if (err !== 1'b1 || entry_bcd !== 24'h190000 || digit_cnt !== 3'd2) begin
         n_fail++; $display("FAIL mten_reject got err=%0b ent=%h cnt=%0d exp 1/190000/2", err, entry_bcd, digit_cnt); end
      repeat (ERR_HOLD) tick(1'b0, 4'h0);
      press(4'hA); press(4'd1); press(4'd9); press(4'd3); press(4'd0); press(4'd0); press(4'hF);
      n_checks++; if (err !== 1'b1 || load_en !== 1'b0 || digit_cnt !== 3'd5 || entry_bcd !== 24'h193000) begin
         n_fail++; $display("FAIL early_enter got err=%0b ld=%0b cnt=%0d ent=%h exp 1/0/5/193000", err, load_en, digit_cnt, entry_bcd); end
      repeat (ERR_HOLD) tick(1'b0, 4'h0);
      press(4'hC);
      n_checks++; if (busy !== 1'b0 || n_loads != l0) begin n_fail++; $display("FAIL bksp_no_load got busy=%0b loads=%0d exp 0/0", busy, n_loads - l0); end
   endtask

   task automatic test_timeout();
      int l0 = n_loads;
      press(4'hA); press(4'd0); press(4'd8); press(4'd3); press(4'd0);
      repeat (TIMEOUT - 1) tick(1'b0, 4'h0);
      n_checks++; if (busy !== 1'b1 || entry_bcd !== 24'h083000) begin n_fail++; $display("FAIL timeout_early got busy=%0b ent=%h exp 1/083000", busy, entry_bcd); end
      tick(1'b0, 4'h0);
      n_checks++; if (busy !== 1'b0 || entry_bcd !== 24'h0 || digit_cnt !== 3'd0 || err !== 1'b0 || n_loads != l0) begin
         n_fail++; $display("FAIL timeout_abort got busy=%0b ent=%h cnt=%0d err=%0b loads=%0d exp 0/0/0/0/0", busy, entry_bcd, digit_cnt, err, n_loads - l0); end
      press(4'hA); press(4'd0); press(4'd8); press(4'hC);
      n_checks++; if (busy !== 1'b0 || entry_bcd !== 24'h0 || n_loads != l0) begin
         n_fail++; $display("FAIL cancel got busy=%0b ent=%h loads=%0d exp 0/0/0", busy, entry_bcd, n_loads - l0); end
   endtask

   task automatic test_overflow_ignore();
      press(4'hA); press(4'd0); press(4'd9); press(4'd1); press(4'd5); press(4'd3); press(4'd0); press(4'd7);
      n_checks++; if (digit_cnt !== 3'd6 || entry_bcd !== 24'h091530 || err !== 1'b0) begin
         n_fail++; $display("FAIL seventh_digit got cnt=%0d ent=%h err=%0b exp 6/091530/0", digit_cnt, entry_bcd, err); end
      press(4'hD); press(4'hE);
      n_checks++; if (digit_cnt !== 3'd6 || entry_bcd !== 24'h091530 || err !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL ignored_keys got cnt=%0d ent=%h err=%0b busy=%0b exp 6/091530/0/1", digit_cnt, entry_bcd, err, busy); end
      press(4'hF);
      n_checks++; if (load_en !== 1'b1 || load_bcd !== 24'h091530) begin n_fail++; $display("FAIL overflow_load got %0b/%h exp 1/091530", load_en, load_bcd); end
   endtask

   task automatic test_random();
      int sel;
      logic [3:0] c;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            sel = $urandom_range(0, 19);
            if (sel < 12)       c = 4'($urandom_range(0, 5));
            else if (sel < 14)  c = 4'($urandom_range(6, 9));
            else if (sel == 14) c = 4'hB;
            else if (sel == 15) c = 4'hA;
            else if (sel == 16) c = 4'hC;
            else if (sel == 17) c = 4'hD;
            else if (sel == 18) c = 4'hE;
            else                c = 4'hF;
            press(c);
         end else begin
            tick(1'b0, 4'($urandom_range(0, 15)));
         end
         n_checks++; if (busy !== (m_mode != M_IDLE)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %0b exp %0b", n, busy, m_mode != M_IDLE); end
         n_checks++; if (err !== (m_mode == M_ERROR)) begin n_fail++; $display("FAIL rnd_err cyc %0d got %0b exp %0b", n, err, m_mode == M_ERROR); end
         n_checks++; if (entry_bcd !== m_pack() || digit_cnt !== 3'(m_dig.size())) begin
            n_fail++; $display("FAIL rnd_entry cyc %0d got %h/%0d exp %h/%0d", n, entry_bcd, digit_cnt, m_pack(), m_dig.size()); end
         n_checks++; if (load_en !== m_load || load_bcd !== m_load_bcd) begin
            n_fail++; $display("FAIL rnd_load cyc %0d got %0b/%h exp %0b/%h", n, load_en, load_bcd, m_load, m_load_bcd); end
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_error_hold();
      test_backspace();
      test_timeout();
      test_overflow_ignore();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
